flags_register_file: RTL and testbench

- Small register file of 1-bit status flags, one flag per channel/slot. Sits between the receive (RX) path and the processor core.
- The RX path sets a flag when data for that slot has arrived.
- The core's ready-to-receive (RTR) path clears the flag once it has consumed the slot.
- The core polls any flag through an independent combinational read port.

---
 rtl/flags_rf_pkg.sv | 11 +
 rtl/flag_cell.sv | 33 +++
 rtl/flags_register_file.sv | 39 +++
 tb/tb_flags_register_file.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flags_rf_pkg.sv
// Shared constants and sizing helper for the flags register file.
package flags_rf_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 1;

    // Number of flags addressed by an address port of the given width.
    function automatic int num_flags(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/flag_cell.sv
// Single status flag: async active-low reset, set and clear inputs, set wins.
module flag_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic set_i,
    input  logic clr_i,
    output logic flag_o
);

    logic flag_q;
    logic flag_d;

    // Set has priority so an arriving packet is never lost to a same-cycle consume.
    always_comb begin
        flag_d = flag_q;
        if (set_i) begin
            flag_d = 1'b1;
        end else if (clr_i) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/flags_register_file.sv
// Per-slot arrival flags: RX sets, RTR clears, core polls through a combinational read port.
module flags_register_file
    import flags_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_write_enable,
    input  logic                  rtr_write_enable,
    input  logic [ADDR_WIDTH-1:0] address_1,
    input  logic [ADDR_WIDTH-1:0] address_2,
    input  logic [ADDR_WIDTH-1:0] address_3,
    output logic                  read_data
);

    localparam int NUM_FLAGS = num_flags(ADDR_WIDTH);

    logic [NUM_FLAGS-1:0] flags;
    logic [NUM_FLAGS-1:0] set_vec;
    logic [NUM_FLAGS-1:0] clr_vec;

    for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_cell
        assign set_vec[i] = rx_write_enable  && (address_1 == ADDR_WIDTH'(i));
        assign clr_vec[i] = rtr_write_enable && (address_2 == ADDR_WIDTH'(i));

        flag_cell u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .set_i  (set_vec[i]),
            .clr_i  (clr_vec[i]),
            .flag_o (flags[i])
        );
    end

    // No bypass: a write becomes visible only after the edge that stores it.
    assign read_data = flags[address_3];

endmodule

// File: tb/tb_flags_register_file.sv
// Randomized self-checking bench for flags_register_file against an array model.
module tb_flags_register_file;

    localparam int AW = 2;
    localparam int NF = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          rx_write_enable;
    logic          rtr_write_enable;
    logic [AW-1:0] address_1;
    logic [AW-1:0] address_2;
    logic [AW-1:0] address_3;
    logic          read_data;

    int tests_run;
    int tests_failed;

    bit model [NF];

    flags_register_file #(.ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rx_write_enable  (rx_write_enable),
        .rtr_write_enable (rtr_write_enable),
        .address_1        (address_1),
        .address_2        (address_2),
        .address_3        (address_3),
        .read_data        (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; the model applies the same edge using the spec rules.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < NF; i++) model[i] = 1'b0;
        end else begin
            if (rtr_write_enable) model[address_2] = 1'b0;
            if (rx_write_enable)  model[address_1] = 1'b1;
        end
        #1;
    endtask

    task automatic read_flag(input logic [AW-1:0] a, output logic v);
        address_3 = a;
        #1;
        v = read_data;
    endtask

    task automatic idle_inputs();
        rx_write_enable  = 1'b0;
        rtr_write_enable = 1'b0;
        address_1        = '0;
        address_2        = '0;
    endtask

    task automatic test_reset();
        logic v;
        // Power-up reset.
        for (int i = 0; i < NF; i++) begin
            read_flag(AW'(i), v);
            tests_run++;
            if (v !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_power_up addr=%0d got=%b exp=0", i, v);
            end
        end
        rst_n = 1'b1;
        step();
        // Set every flag, then assert reset with no clock edge.
        rx_write_enable = 1'b1;
        for (int i = 0; i < NF; i++) begin
            address_1 = AW'(i);
            step();
        end
        rx_write_enable = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < NF; i++) model[i] = 1'b0;
        for (int i = 0; i < NF; i++) begin
            read_flag(AW'(i), v);
            tests_run++;
            if (v !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_async addr=%0d got=%b exp=0", i, v);
            end
        end
        // Writes attempted during reset must be ignored.
        rx_write_enable = 1'b1;
        address_1 = AW'(1);
        step();
        rx_write_enable = 1'b0;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < NF; i++) begin
            read_flag(AW'(i), v);
            tests_run++;
            if (v !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_release addr=%0d got=%b exp=0", i, v);
            end
        end
    endtask

    task automatic test_rx_set();
        logic v;
        rx_write_enable = 1'b1;
        address_1 = AW'(0);
        step();
        address_1 = AW'(1);
        step();
        rx_write_enable = 1'b0;
        for (int i = 0; i < NF; i++) begin
            read_flag(AW'(i), v);
            tests_run++;
            if (v !== model[i]) begin
                tests_failed++;
                $display("FAIL rx_set addr=%0d got=%b exp=%b", i, v, model[i]);
            end
        end
    endtask

    task automatic test_rtr_clear();
        logic v;
        rtr_write_enable = 1'b1;
        address_2 = AW'(0);
        step();
        address_2 = AW'(1);
        step();
        rtr_write_enable = 1'b0;
        for (int i = 0; i < NF; i++) begin
            read_flag(AW'(i), v);
            tests_run++;
            if (v !== model[i]) begin
                tests_failed++;
                $display("FAIL rtr_clear addr=%0d got=%b exp=%b", i, v, model[i]);
            end
        end
    endtask

    task automatic test_collision();
        logic v;
        // Same address, flag starts clear: set wins.
        rx_write_enable  = 1'b1;
        rtr_write_enable = 1'b1;
        address_1 = AW'(1);
        address_2 = AW'(1);
        step();
        idle_inputs();
        read_flag(AW'(1), v);
        tests_run++;
        if (v !== 1'b1) begin
            tests_failed++;
            $display("FAIL collision_same got=%b exp=1", v);
        end
        // Both flags set, then set 0 while clearing 1.
        rx_write_enable = 1'b1;
        address_1 = AW'(0);
        step();
        rtr_write_enable = 1'b1;
        address_1 = AW'(0);
        address_2 = AW'(1);
        step();
        idle_inputs();
        for (int i = 0; i < NF; i++) begin
            read_flag(AW'(i), v);
            tests_run++;
            if (v !== model[i]) begin
                tests_failed++;
                $display("FAIL collision_diff addr=%0d got=%b exp=%b", i, v, model[i]);
            end
        end
    endtask

    task automatic test_read_latency();
        logic v;
        rtr_write_enable = 1'b1;
        for (int i = 0; i < NF; i++) begin
            address_2 = AW'(i);
            step();
        end
        idle_inputs();
        rx_write_enable = 1'b1;
        address_1 = AW'(0);
        read_flag(AW'(0), v);
        tests_run++;
        if (v !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_before_edge got=%b exp=0", v);
        end
        step();
        rx_write_enable = 1'b0;
        v = read_data;
        tests_run++;
        if (v !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_after_edge got=%b exp=1", v);
        end
        // Address change alone must update the read port.
        read_flag(AW'(1), v);
        tests_run++;
        if (v !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_addr_change got=%b exp=0", v);
        end
        read_flag(AW'(0), v);
        tests_run++;
        if (v !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_addr_back got=%b exp=1", v);
        end
    endtask

    task automatic test_hold();
        logic v;
        bit snap [NF];
        rx_write_enable = 1'b1;
        address_1 = AW'(2);
        step();
        idle_inputs();
        for (int i = 0; i < NF; i++) snap[i] = model[i];
        for (int c = 0; c < 10; c++) begin
            address_1 = AW'($urandom_range(0, NF - 1));
            address_2 = AW'($urandom_range(0, NF - 1));
            step();
        end
        for (int i = 0; i < NF; i++) begin
            read_flag(AW'(i), v);
            tests_run++;
            if (v !== snap[i]) begin
                tests_failed++;
                $display("FAIL hold addr=%0d got=%b exp=%b", i, v, snap[i]);
            end
        end
    endtask

    task automatic test_random();
        logic v;
        logic [AW-1:0] ra;
        for (int c = 0; c < 300; c++) begin
            rx_write_enable  = 1'($urandom_range(0, 1));
            rtr_write_enable = 1'($urandom_range(0, 1));
            address_1 = AW'($urandom_range(0, NF - 1));
            address_2 = AW'($urandom_range(0, NF - 1));
            step();
            ra = AW'($urandom_range(0, NF - 1));
            read_flag(ra, v);
            tests_run++;
            if (v !== model[ra]) begin
                tests_failed++;
                $display("FAIL random cycle=%0d addr=%0d got=%b exp=%b", c, ra, v, model[ra]);
            end
        end
        idle_inputs();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < NF; i++) model[i] = 1'b0;
        rst_n = 1'b0;
        idle_inputs();
        address_3 = '0;
        #1;
        test_reset();
        test_rx_set();
        test_rtr_clear();
        test_collision();
        test_read_latency();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
